// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button synchroniser, debouncer and toggle/pulse control outputs
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Btn_Stop,
    input  logic       Btn_Reverse,
    input  logic       Btn_Clear,
    output logic       Stop,
    output logic       Reverse,
    output logic       Clear,
    output logic [2:0] Btn_Level
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // channel order everywhere: bit 0 = stop, bit 1 = reverse, bit 2 = clear
    logic [2:0]       raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       stable;
    logic [CNT_W-1:0] cnt [3];
    logic [2:0]       accept;
    logic [2:0]       press;

    assign raw       = {Btn_Clear, Btn_Reverse, Btn_Stop};
    assign Btn_Level = stable;

    // two-flop synchroniser for the asynchronous raw buttons
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            s1 <= 3'b000;
            s2 <= 3'b000;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // accept a new level once it has differed from the stable level for DEBOUNCE_CYCLES clocks
    always_comb begin
        accept = 3'b000;
        press  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
            press[i]  = accept[i] && s2[i];
        end
    end

    // per-channel debounce counters; any return to the stable level restarts the count
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            stable <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // control outputs: clear wins over same-cycle toggles, stop and reverse toggle independently
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            Stop    <= 1'b0;
            Reverse <= 1'b0;
            Clear   <= 1'b0;
        end else if (press[2]) begin
            Stop    <= 1'b0;
            Reverse <= 1'b0;
            Clear   <= 1'b1;
        end else begin
            Clear <= 1'b0;
            if (press[0]) begin
                Stop <= ~Stop;
            end
            if (press[1]) begin
                Reverse <= ~Reverse;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic       CLK;
    logic       Reset;
    logic       Btn_Stop;
    logic       Btn_Reverse;
    logic       Btn_Clear;
    logic       Stop;
    logic       Reverse;
    logic       Clear;
    logic [2:0] Btn_Level;

    int errors = 0;
    int checks = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Btn_Stop    (Btn_Stop),
        .Btn_Reverse (Btn_Reverse),
        .Btn_Clear   (Btn_Clear),
        .Stop        (Stop),
        .Reverse     (Reverse),
        .Clear       (Clear),
        .Btn_Level   (Btn_Level)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0; Btn_Stop = 1'b1; Btn_Reverse = 1'b1; Btn_Clear = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if ({Stop, Reverse, Clear, Btn_Level} !== 6'b000000) begin
                $display("FAIL reset_hold edge %0d: got %b want 000000", i, {Stop, Reverse, Clear, Btn_Level});
                errors++;
            end
        end
        Reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (Btn_Level[0] !== (i == 6)) begin
                $display("FAIL reset_release_level edge %0d: got %b want %b", i, Btn_Level[0], (i == 6));
                errors++;
            end
        end
        checks++;
        if ({Clear, Stop, Reverse} !== 3'b100) begin
            $display("FAIL reset_release_clear: got %b want 100", {Clear, Stop, Reverse});
            errors++;
        end
        tick();
        checks++;
        if (Clear !== 1'b0) begin
            $display("FAIL reset_clear_one_cycle: got %b want 0", Clear);
            errors++;
        end
        Btn_Stop = 1'b0; Btn_Reverse = 1'b0; Btn_Clear = 1'b0;
        settle(8);
        checks++;
        if ({Btn_Level, Stop, Reverse, Clear} !== 6'b000000) begin
            $display("FAIL reset_after_release: got %b want 000000", {Btn_Level, Stop, Reverse, Clear});
            errors++;
        end
    endtask

    task automatic test_clean_press();
        Btn_Stop = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (Stop !== (i >= 6) || Clear !== 1'b0) begin
                $display("FAIL clean_press edge %0d: got stop=%b clear=%b want stop=%b clear=0", i, Stop, Clear, (i >= 6));
                errors++;
            end
        end
        Btn_Stop = 1'b0;
        settle(8);
        checks++;
        if (Stop !== 1'b1 || Btn_Level[0] !== 1'b0) begin
            $display("FAIL clean_release: got stop=%b lvl=%b want stop=1 lvl=0", Stop, Btn_Level[0]);
            errors++;
        end
        Btn_Stop = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (Stop !== (i < 6) || Clear !== 1'b0) begin
                $display("FAIL second_press edge %0d: got stop=%b clear=%b want stop=%b clear=0", i, Stop, Clear, (i < 6));
                errors++;
            end
        end
        Btn_Stop = 1'b0;
        settle(8);
    endtask

    task automatic test_bounce();
        for (int p = 0; p < 4; p++) begin
            Btn_Reverse = (p % 2 == 0);
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++;
                if (Reverse !== 1'b0 || Btn_Level[1] !== 1'b0) begin
                    $display("FAIL bounce phase %0d: got rev=%b lvl=%b want 0 0", p, Reverse, Btn_Level[1]);
                    errors++;
                end
            end
        end
        Btn_Reverse = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (Reverse !== (i >= 6)) begin
                $display("FAIL bounce_settle edge %0d: got %b want %b", i, Reverse, (i >= 6));
                errors++;
            end
        end
        Btn_Reverse = 1'b0;
        settle(8);
        checks++;
        if (Reverse !== 1'b1 || Stop !== 1'b0) begin
            $display("FAIL bounce_single_toggle: got rev=%b stop=%b want 1 0", Reverse, Stop);
            errors++;
        end
    endtask

    task automatic test_clear_priority();
        Btn_Stop = 1'b1;
        settle(6);
        Btn_Stop = 1'b0;
        settle(8);
        checks++;
        if ({Stop, Reverse} !== 2'b11) begin
            $display("FAIL clear_setup: got %b want 11", {Stop, Reverse});
            errors++;
        end
        Btn_Clear = 1'b1; Btn_Stop = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if ({Clear, Stop, Reverse} !== ((i < 6) ? 3'b011 : (i == 6) ? 3'b100 : 3'b000)) begin
                $display("FAIL clear_priority edge %0d: got %b want %b", i, {Clear, Stop, Reverse},
                         ((i < 6) ? 3'b011 : (i == 6) ? 3'b100 : 3'b000));
                errors++;
            end
        end
        Btn_Clear = 1'b0; Btn_Stop = 1'b0;
        settle(8);
    endtask

    task automatic test_simultaneous();
        Btn_Stop = 1'b1; Btn_Reverse = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if ({Stop, Reverse, Clear} !== ((i == 6) ? 3'b110 : 3'b000)) begin
                $display("FAIL simultaneous edge %0d: got %b want %b", i, {Stop, Reverse, Clear}, ((i == 6) ? 3'b110 : 3'b000));
                errors++;
            end
        end
        Btn_Stop = 1'b0; Btn_Reverse = 1'b0;
        settle(8);
    endtask

    task automatic test_reset_mid_debounce();
        Btn_Stop = 1'b1;
        settle(3);
        Reset = 1'b0;
        tick();
        checks++;
        if ({Stop, Reverse, Clear, Btn_Level} !== 6'b000000) begin
            $display("FAIL mid_reset: got %b want 000000", {Stop, Reverse, Clear, Btn_Level});
            errors++;
        end
        Reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (Stop !== (i >= 6) || Clear !== 1'b0) begin
                $display("FAIL mid_reset_recover edge %0d: got stop=%b clear=%b want stop=%b clear=0", i, Stop, Clear, (i >= 6));
                errors++;
            end
        end
        Btn_Stop = 1'b0;
        settle(8);
    endtask

    initial begin
        Reset = 1'b0; Btn_Stop = 1'b0; Btn_Reverse = 1'b0; Btn_Clear = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_clear_priority();
        test_simultaneous();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
